// File: rtl/sram_arbiter_if.sv
// CPU-side and SRAM-side signal bundle for sram_arbiter.
// The arbiter uses the slave modport; the CPU/SRAM environment uses master.
interface sram_arbiter_if;
    logic        iread_ce;
    logic [31:0] iram_addr;
    logic [31:0] ram_inst;
    logic        irom_fin;

    logic        dread_ce;
    logic [31:0] dram_read_addr;
    logic        dwrite_ce;
    logic [31:0] dram_write_addr;
    logic [31:0] wdata;
    logic [3:0]  dbe;
    logic [31:0] ram_rdata;
    logic        stall_mem;

    logic [19:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic [3:0]  sram_be_n;

    modport slave (
        input  iread_ce, iram_addr, dread_ce, dram_read_addr, dwrite_ce,
               dram_write_addr, wdata, dbe, sram_rdata,
        output ram_inst, irom_fin, ram_rdata, stall_mem, sram_addr, sram_wdata,
               sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
    );

    modport master (
        output iread_ce, iram_addr, dread_ce, dram_read_addr, dwrite_ce,
               dram_write_addr, wdata, dbe, sram_rdata,
        input  ram_inst, irom_fin, ram_rdata, stall_mem, sram_addr, sram_wdata,
               sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
    );
endinterface

// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter sharing one async SRAM between CPU fetch and load/store.
// Define SRAM_TURNAROUND_EN to insert a bus-turnaround idle cycle after every write.
module sram_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    sram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, DATA_RD, DATA_WR, INST_RD} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       d_done;
    logic       data_req;
    logic       bus_free;

`ifdef SRAM_TURNAROUND_EN
    // Counts down through the d_done cycle and the extra turnaround cycle.
    logic [1:0] ta_cnt;
    assign bus_free = (ta_cnt == 2'd0);
`else
    assign bus_free = 1'b1;
`endif

    assign data_req = bus.dread_ce | bus.dwrite_ce;

    assign bus.stall_mem = ((state == IDLE) && data_req && !d_done)
                         || (state == DATA_RD) || (state == DATA_WR)
                         || ((state == INST_RD) && data_req);

    // Only word-address bits reach the SRAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.iram_addr[31:22], bus.iram_addr[1:0],
                                bus.dram_read_addr[31:22], bus.dram_read_addr[1:0],
                                bus.dram_write_addr[31:22], bus.dram_write_addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            d_done         <= 1'b0;
            bus.ram_inst   <= 32'd0;
            bus.ram_rdata  <= 32'd0;
            bus.irom_fin   <= 1'b0;
            bus.sram_addr  <= 20'd0;
            bus.sram_wdata <= 32'd0;
            bus.sram_ce_n  <= 1'b1;
            bus.sram_oe_n  <= 1'b1;
            bus.sram_we_n  <= 1'b1;
            bus.sram_be_n  <= 4'hF;
`ifdef SRAM_TURNAROUND_EN
            ta_cnt         <= 2'd0;
`endif
        end else begin
            d_done       <= 1'b0;
            bus.irom_fin <= 1'b0;
`ifdef SRAM_TURNAROUND_EN
            if (ta_cnt != 2'd0) begin
                ta_cnt <= ta_cnt - 2'd1;
            end
`endif
            case (state)
                IDLE: begin
                    if (bus_free) begin
                        // A data request that just completed is not re-issued while d_done is set.
                        if (!d_done && bus.dwrite_ce) begin
                            state          <= DATA_WR;
                            cnt            <= CNT_LOAD;
                            bus.sram_addr  <= bus.dram_write_addr[21:2];
                            bus.sram_wdata <= bus.wdata;
                            bus.sram_ce_n  <= 1'b0;
                            bus.sram_oe_n  <= 1'b1;
                            bus.sram_we_n  <= 1'b0;
                            bus.sram_be_n  <= ~bus.dbe;
                        end else if (!d_done && bus.dread_ce) begin
                            state         <= DATA_RD;
                            cnt           <= CNT_LOAD;
                            bus.sram_addr <= bus.dram_read_addr[21:2];
                            bus.sram_ce_n <= 1'b0;
                            bus.sram_oe_n <= 1'b0;
                            bus.sram_we_n <= 1'b1;
                            bus.sram_be_n <= 4'h0;
                        end else if (bus.iread_ce) begin
                            state         <= INST_RD;
                            cnt           <= CNT_LOAD;
                            bus.sram_addr <= bus.iram_addr[21:2];
                            bus.sram_ce_n <= 1'b0;
                            bus.sram_oe_n <= 1'b0;
                            bus.sram_we_n <= 1'b1;
                            bus.sram_be_n <= 4'h0;
                        end
                    end
                end
                default: begin
                    if (cnt == 4'd0) begin
                        state         <= IDLE;
                        bus.sram_ce_n <= 1'b1;
                        bus.sram_oe_n <= 1'b1;
                        bus.sram_we_n <= 1'b1;
                        bus.sram_be_n <= 4'hF;
                        if (state == DATA_RD) begin
                            bus.ram_rdata <= bus.sram_rdata;
                            d_done        <= 1'b1;
                        end else if (state == DATA_WR) begin
                            d_done <= 1'b1;
`ifdef SRAM_TURNAROUND_EN
                            ta_cnt <= 2'd2;
`endif
                        end else begin
                            bus.ram_inst <= bus.sram_rdata;
                            bus.irom_fin <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                        // Release write-enable for the last cycle so data holds past the WE rising edge.
                        if ((state == DATA_WR) && (cnt == 4'd1)) begin
                            bus.sram_we_n <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with WAIT_CYCLES=2; honours SRAM_TURNAROUND_EN.
module tb_sram_arbiter;

`ifdef SRAM_TURNAROUND_EN
    localparam logic TA = 1'b1;
`else
    localparam logic TA = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_asserts = 0;
    int   n_fail = 0;

    sram_arbiter_if bus ();

    sram_arbiter #(.WAIT_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.iread_ce = 1'b0; bus.iram_addr = 32'd0;
        bus.dread_ce = 1'b0; bus.dram_read_addr = 32'd0;
        bus.dwrite_ce = 1'b0; bus.dram_write_addr = 32'd0;
        bus.wdata = 32'd0; bus.dbe = 4'h0; bus.sram_rdata = 32'd0;

        // Reset state
        rst = 1'b1;
        cyc(); cyc(); #1;
        chk("rst_ce_n", bus.sram_ce_n, 1'b1);
        chk("rst_oe_n", bus.sram_oe_n, 1'b1);
        chk("rst_we_n", bus.sram_we_n, 1'b1);
        chk("rst_be_n", bus.sram_be_n, 4'hF);
        chk("rst_addr", bus.sram_addr, 20'h0);
        chk("rst_wdata", bus.sram_wdata, 32'h0);
        chk("rst_rdata", bus.ram_rdata, 32'h0);
        chk("rst_inst", bus.ram_inst, 32'h0);
        chk("rst_fin", bus.irom_fin, 1'b0);
        chk("rst_stall", bus.stall_mem, 1'b0);
        rst = 1'b0;

        // Fetch only
        cyc(); bus.iread_ce = 1'b1; bus.iram_addr = 32'h8000_0010; bus.sram_rdata = 32'h2402_0005; #1;
        chk("f0_stall", bus.stall_mem, 1'b0);
        chk("f0_oe_n", bus.sram_oe_n, 1'b1);
        cyc(); bus.iread_ce = 1'b0; #1;
        chk("f1_oe_n", bus.sram_oe_n, 1'b0);
        chk("f1_ce_n", bus.sram_ce_n, 1'b0);
        chk("f1_we_n", bus.sram_we_n, 1'b1);
        chk("f1_be_n", bus.sram_be_n, 4'h0);
        chk("f1_addr", bus.sram_addr, 20'h00004);
        chk("f1_stall", bus.stall_mem, 1'b0);
        cyc(); #1;
        chk("f2_oe_n", bus.sram_oe_n, 1'b0);
        chk("f2_fin", bus.irom_fin, 1'b0);
        cyc(); #1;
        chk("f3_oe_n", bus.sram_oe_n, 1'b1);
        chk("f3_fin", bus.irom_fin, 1'b1);
        chk("f3_inst", bus.ram_inst, 32'h2402_0005);
        cyc(); #1;
        chk("f4_fin", bus.irom_fin, 1'b0);
        chk("f4_inst", bus.ram_inst, 32'h2402_0005);

        // Load
        cyc(); bus.dread_ce = 1'b1; bus.dram_read_addr = 32'h8040_0008; bus.sram_rdata = 32'hDEAD_BEEF; #1;
        chk("l0_stall", bus.stall_mem, 1'b1);
        cyc(); #1;
        chk("l1_stall", bus.stall_mem, 1'b1);
        chk("l1_oe_n", bus.sram_oe_n, 1'b0);
        chk("l1_addr", bus.sram_addr, 20'h00002);
        cyc(); #1;
        chk("l2_stall", bus.stall_mem, 1'b1);
        cyc(); #1;
        chk("l3_stall", bus.stall_mem, 1'b0);
        chk("l3_rdata", bus.ram_rdata, 32'hDEAD_BEEF);
        chk("l3_oe_n", bus.sram_oe_n, 1'b1);
        bus.dread_ce = 1'b0;
        cyc(); #1;
        chk("l4_oe_n", bus.sram_oe_n, 1'b1);
        chk("l4_stall", bus.stall_mem, 1'b0);

        // Store: address bits 21:2 of 0x80400004
        cyc(); bus.dwrite_ce = 1'b1; bus.dram_write_addr = 32'h8040_0004;
        bus.wdata = 32'h1234_5678; bus.dbe = 4'b0011; #1;
        chk("s0_stall", bus.stall_mem, 1'b1);
        chk("s0_we_n", bus.sram_we_n, 1'b1);
        cyc(); #1;
        chk("s1_stall", bus.stall_mem, 1'b1);
        chk("s1_we_n", bus.sram_we_n, 1'b0);
        chk("s1_oe_n", bus.sram_oe_n, 1'b1);
        chk("s1_be_n", bus.sram_be_n, 4'b1100);
        chk("s1_addr", bus.sram_addr, 20'h00001);
        chk("s1_wdata", bus.sram_wdata, 32'h1234_5678);
        cyc(); #1;
        chk("s2_we_n", bus.sram_we_n, 1'b1);
        chk("s2_ce_n", bus.sram_ce_n, 1'b0);
        chk("s2_stall", bus.stall_mem, 1'b1);
        cyc(); #1;
        chk("s3_stall", bus.stall_mem, 1'b0);
        chk("s3_ce_n", bus.sram_ce_n, 1'b1);
        chk("s3_be_n", bus.sram_be_n, 4'hF);
        bus.dwrite_ce = 1'b0;
        cyc(); #1;
        chk("s4_stall", bus.stall_mem, 1'b0);

        // Simultaneous fetch and load: load first
        cyc(); bus.iread_ce = 1'b1; bus.iram_addr = 32'h8000_0020;
        bus.dread_ce = 1'b1; bus.dram_read_addr = 32'h8000_0100; bus.sram_rdata = 32'hAAAA_5555; #1;
        chk("p0_stall", bus.stall_mem, 1'b1);
        cyc(); #1;
        chk("p1_addr", bus.sram_addr, 20'h00040);
        chk("p1_oe_n", bus.sram_oe_n, 1'b0);
        chk("p1_stall", bus.stall_mem, 1'b1);
        cyc(); #1;
        chk("p2_stall", bus.stall_mem, 1'b1);
        cyc(); #1;
        chk("p3_stall", bus.stall_mem, 1'b0);
        chk("p3_rdata", bus.ram_rdata, 32'hAAAA_5555);
        chk("p3_oe_n", bus.sram_oe_n, 1'b1);
        bus.dread_ce = 1'b0; bus.sram_rdata = 32'h1122_3344;
        cyc(); #1;
        chk("p4_addr", bus.sram_addr, 20'h00008);
        chk("p4_oe_n", bus.sram_oe_n, 1'b0);
        chk("p4_stall", bus.stall_mem, 1'b0);
        bus.iread_ce = 1'b0;
        cyc(); #1;
        chk("p5_fin", bus.irom_fin, 1'b0);
        cyc(); #1;
        chk("p6_fin", bus.irom_fin, 1'b1);
        chk("p6_inst", bus.ram_inst, 32'h1122_3344);
        chk("p6_rdata", bus.ram_rdata, 32'hAAAA_5555);

        // Store then load: turnaround delays the load by one cycle
        cyc(); bus.dwrite_ce = 1'b1; bus.dram_write_addr = 32'h8000_0040;
        bus.wdata = 32'hCAFE_F00D; bus.dbe = 4'hF; #1;
        chk("t0_stall", bus.stall_mem, 1'b1);
        cyc(); #1;
        chk("t1_be_n", bus.sram_be_n, 4'h0);
        chk("t1_we_n", bus.sram_we_n, 1'b0);
        cyc(); #1;
        chk("t2_stall", bus.stall_mem, 1'b1);
        cyc(); #1;
        chk("t3_stall", bus.stall_mem, 1'b0);
        bus.dwrite_ce = 1'b0; bus.dread_ce = 1'b1;
        bus.dram_read_addr = 32'h8000_0044; bus.sram_rdata = 32'h0BAD_F00D;
        cyc(); #1;
        chk("t4_stall", bus.stall_mem, 1'b1);
        chk("t4_oe_n", bus.sram_oe_n, 1'b1);
        cyc(); #1;
        chk("t5_oe_n", bus.sram_oe_n, TA);
        chk("t5_stall", bus.stall_mem, 1'b1);
        cyc(); #1;
        chk("t6_oe_n", bus.sram_oe_n, 1'b0);
        chk("t6_stall", bus.stall_mem, 1'b1);
        cyc(); #1;
        chk("t7_stall", bus.stall_mem, TA);
        if (!bus.stall_mem) bus.dread_ce = 1'b0;
        cyc(); #1;
        chk("t8_stall", bus.stall_mem, 1'b0);
        chk("t8_rdata", bus.ram_rdata, 32'h0BAD_F00D);
        bus.dread_ce = 1'b0;
        cyc(); #1;
        chk("t9_oe_n", bus.sram_oe_n, 1'b1);
        chk("t9_stall", bus.stall_mem, 1'b0);

        // Back-to-back loads
        cyc(); bus.dread_ce = 1'b1; bus.dram_read_addr = 32'h8000_0080; bus.sram_rdata = 32'h0102_0304; #1;
        chk("b0_stall", bus.stall_mem, 1'b1);
        cyc(); cyc(); #1;
        chk("b2_stall", bus.stall_mem, 1'b1);
        cyc(); #1;
        chk("b3_stall", bus.stall_mem, 1'b0);
        chk("b3_rdata", bus.ram_rdata, 32'h0102_0304);
        bus.dram_read_addr = 32'h8000_0084; bus.sram_rdata = 32'h0506_0708;
        cyc(); #1;
        chk("b4_stall", bus.stall_mem, 1'b1);
        chk("b4_oe_n", bus.sram_oe_n, 1'b1);
        cyc(); #1;
        chk("b5_oe_n", bus.sram_oe_n, 1'b0);
        chk("b5_addr", bus.sram_addr, 20'h00021);
        cyc(); cyc(); #1;
        chk("b7_stall", bus.stall_mem, 1'b0);
        chk("b7_rdata", bus.ram_rdata, 32'h0506_0708);
        bus.dread_ce = 1'b0;

        // Write wins over read
        cyc(); bus.dwrite_ce = 1'b1; bus.dread_ce = 1'b1;
        bus.dram_write_addr = 32'h8000_0010; bus.dram_read_addr = 32'h8000_0200; bus.dbe = 4'b1010; #1;
        chk("w0_stall", bus.stall_mem, 1'b1);
        cyc(); #1;
        chk("w1_we_n", bus.sram_we_n, 1'b0);
        chk("w1_oe_n", bus.sram_oe_n, 1'b1);
        chk("w1_addr", bus.sram_addr, 20'h00004);
        chk("w1_be_n", bus.sram_be_n, 4'b0101);
        cyc(); cyc(); #1;
        chk("w3_stall", bus.stall_mem, 1'b0);
        bus.dwrite_ce = 1'b0; bus.dread_ce = 1'b0;
        cyc();

        // Reset during second cycle of a load
        cyc(); bus.dread_ce = 1'b1; bus.dram_read_addr = 32'h8000_0008; bus.sram_rdata = 32'h55AA_55AA; #1;
        chk("r0_stall", bus.stall_mem, 1'b1);
        cyc(); #1;
        chk("r1_oe_n", bus.sram_oe_n, 1'b0);
        cyc(); rst = 1'b1; bus.dread_ce = 1'b0; #1;
        chk("r2_oe_n", bus.sram_oe_n, 1'b0);
        cyc(); #1;
        chk("r3_oe_n", bus.sram_oe_n, 1'b1);
        chk("r3_ce_n", bus.sram_ce_n, 1'b1);
        chk("r3_we_n", bus.sram_we_n, 1'b1);
        chk("r3_be_n", bus.sram_be_n, 4'hF);
        chk("r3_rdata", bus.ram_rdata, 32'h0);
        chk("r3_inst", bus.ram_inst, 32'h0);
        chk("r3_fin", bus.irom_fin, 1'b0);
        chk("r3_addr", bus.sram_addr, 20'h0);
        chk("r3_stall", bus.stall_mem, 1'b0);
        rst = 1'b0;
        cyc(); #1;
        chk("r4_oe_n", bus.sram_oe_n, 1'b1);
        chk("r4_rdata", bus.ram_rdata, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
